// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between the instruction-fetch (IF)
// and memory-stage (MM) requesters. Each granted transaction becomes one RAM
// byte access per cycle. Read bytes are assembled little-endian into a word.
//
// Handshake: a requester raises req and holds req plus its address, size, wr and
// wdata stable until it sees its done pulse. done is high for exactly one cycle.
// On a read, rdata is valid in that cycle and keeps its value until the next
// done on the same port. Requests are only looked at while the FSM is idle.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   if_req, if_addr, if_flush     IF 4-byte read request, address, abort/block
//   if_done, if_rdata             IF completion pulse and assembled word
//   mm_req, mm_wr, mm_len,        MM request, direction, size code
//   mm_addr, mm_wdata             (0=1B, 1=2B, 2/3=4B), address, write data
//   mm_done, mm_rdata             MM completion pulse and zero-extended read word
//   mem_din                       RAM read byte (one cycle after its address)
//   mem_dout, mem_a, mem_wr       RAM write byte, byte address, write enable
//   busy                          FSM is not idle
//   fsm_state                     raw FSM state, for debug
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              mm_req,
    input  logic              mm_wr,
    input  logic [1:0]        mm_len,
    input  logic [ADDR_W-1:0] mm_addr,
    input  logic [31:0]       mm_wdata,
    output logic              mm_done,
    output logic [31:0]       mm_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    output logic              busy,
    output logic [2:0]        fsm_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        RLAST = 3'd2,
        WR    = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t      state;
    logic        owner_mm;   // 1 = current transaction belongs to MM
    logic        last_mm;    // 1 = most recent grant went to MM
    logic [1:0]  idx;        // byte index whose address is on mem_a
    logic [1:0]  last_idx;   // index of the final byte (N-1)
    logic [31:0] wbuf;       // latched MM write data
    logic [31:0] rbuf;       // read bytes collected so far

    // A port that is signalling done this cycle cannot start a new transaction.
    logic if_elig;
    logic mm_elig;
    logic pick_mm;
    logic abort;

    assign if_elig = if_req && !if_done && !if_flush;
    assign mm_elig = mm_req && !mm_done;
    // On a tie the port that did not win last time gets the grant.
    assign pick_mm = mm_elig && (!if_elig || !last_mm);
    // Only an IF read can be cancelled by a flush.
    assign abort   = !owner_mm && if_flush;

    assign busy      = (state != IDLE);
    assign fsm_state = state;

    function automatic logic [1:0] last_of(input logic [1:0] len);
        case (len)
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
        return w[{i, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] i,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[{i, 3'b000} +: 8] = b;
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            owner_mm <= 1'b0;
            last_mm  <= 1'b0;
            idx      <= 2'd0;
            last_idx <= 2'd0;
            wbuf     <= '0;
            rbuf     <= '0;
            if_done  <= 1'b0;
            if_rdata <= '0;
            mm_done  <= 1'b0;
            mm_rdata <= '0;
            mem_dout <= '0;
            mem_a    <= '0;
            mem_wr   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mem_wr <= 1'b0;
                    if (if_elig || mm_elig) begin
                        last_mm  <= pick_mm;
                        owner_mm <= pick_mm;
                        idx      <= 2'd0;
                        rbuf     <= '0;
                        if (pick_mm) begin
                            mem_a    <= mm_addr;
                            last_idx <= last_of(mm_len);
                            if (mm_wr) begin
                                wbuf     <= mm_wdata;
                                mem_dout <= mm_wdata[7:0];
                                mem_wr   <= 1'b1;
                                state    <= WR;
                            end else begin
                                state <= RD;
                            end
                        end else begin
                            mem_a    <= if_addr;
                            last_idx <= 2'd3;
                            state    <= RD;
                        end
                    end
                end
                RD: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        // mem_din now carries the byte addressed last cycle.
                        if (idx != 2'd0)
                            rbuf <= put_byte(rbuf, idx - 2'd1, mem_din);
                        if (idx == last_idx) begin
                            state <= RLAST;
                        end else begin
                            mem_a <= mem_a + ADDR_W'(1);
                            idx   <= idx + 2'd1;
                        end
                    end
                end
                RLAST: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        state <= FIN;
                        if (owner_mm) begin
                            mm_done  <= 1'b1;
                            mm_rdata <= put_byte(rbuf, last_idx, mem_din);
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= put_byte(rbuf, last_idx, mem_din);
                        end
                    end
                end
                WR: begin
                    if (idx == last_idx) begin
                        mem_wr  <= 1'b0;
                        mm_done <= 1'b1;
                        state   <= FIN;
                    end else begin
                        mem_a    <= mem_a + ADDR_W'(1);
                        mem_dout <= byte_of(wbuf, idx + 2'd1);
                        idx      <= idx + 2'd1;
                    end
                end
                FIN: begin
                    if_done <= 1'b0;
                    mm_done <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: a table of single transactions plus
// hand-written sequences for arbitration, flush and reset corner cases.
module tb_mem_arbiter;

    localparam int AW    = 32;
    localparam int RAM_N = 16384;
    localparam int NV    = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_flush = 1'b0;
    logic          if_done;
    logic [31:0]   if_rdata;
    logic          mm_req = 1'b0;
    logic          mm_wr = 1'b0;
    logic [1:0]    mm_len = 2'd0;
    logic [AW-1:0] mm_addr = '0;
    logic [31:0]   mm_wdata = '0;
    logic          mm_done;
    logic [31:0]   mm_rdata;
    logic [7:0]    mem_din;
    logic [7:0]    mem_dout;
    logic [AW-1:0] mem_a;
    logic          mem_wr;
    logic          busy;
    logic [2:0]    fsm_state;

    // clock / reset
    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_rdata(if_rdata),
        .mm_req(mm_req), .mm_wr(mm_wr), .mm_len(mm_len), .mm_addr(mm_addr),
        .mm_wdata(mm_wdata), .mm_done(mm_done), .mm_rdata(mm_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .busy(busy), .fsm_state(fsm_state)
    );

    // RAM model: 16 KiB aliased on the low address bits, one-cycle read latency.
    logic [7:0] ram [0:RAM_N-1];
    logic       ram_load = 1'b1;

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < RAM_N; i++) ram[i] <= 8'hEE;
            ram[14'h0100] <= 8'h11; ram[14'h0101] <= 8'h22;
            ram[14'h0102] <= 8'h33; ram[14'h0103] <= 8'h44;
            ram[14'h0200] <= 8'h9C; ram[14'h0201] <= 8'h8B;
            ram[14'h0202] <= 8'h7A; ram[14'h0203] <= 8'h69;
            ram[14'h3FFE] <= 8'hA5; ram[14'h3FFF] <= 8'h5A;
            ram[14'h0000] <= 8'h01; ram[14'h0001] <= 8'h02;
        end else if (mem_wr) begin
            ram[mem_a[13:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a[13:0]];
    end

    // scoreboard bookkeeping
    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // per-cycle trace of the last transaction, indexed by cycles after T
    logic [AW-1:0] tr_a    [0:15];
    logic          tr_wr   [0:15];
    logic [7:0]    tr_dout [0:15];
    logic          tr_busy [0:15];

    // driver: call at the start of a cycle (just after posedge); the request is
    // seen by the idle FSM in that cycle (offset 0). Returns done offset or -1.
    task automatic run_txn(input bit is_mm, input bit wr, input logic [1:0] len,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int flush_at, output int lat, output logic [31:0] rdata);
        lat   = -1;
        rdata = '0;
        if (is_mm) begin
            mm_req = 1'b1; mm_wr = wr; mm_len = len; mm_addr = addr; mm_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int off = 0; off < 16; off++) begin
            if_flush = (off == flush_at);
            @(negedge clk);
            tr_a[off]    = mem_a;
            tr_wr[off]   = mem_wr;
            tr_dout[off] = mem_dout;
            tr_busy[off] = busy;
            if (is_mm ? mm_done : if_done) begin
                lat   = off;
                rdata = is_mm ? mm_rdata : if_rdata;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if_flush = 1'b0;
        if_req   = 1'b0;
        mm_req   = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          is_mm;
        bit          wr;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t        vecs [NV];
    vec_t        t;
    int          lat;
    int          n;
    int          pulses;
    int          done_cnt;
    logic [31:0] rdata;
    logic [31:0] ea;
    logic [7:0]  act_ev;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 2'd0, 32'h0000_0100, 32'h0,         32'h4433_2211, 6};
        vecs[1] = '{1'b1, 1'b1, 2'd1, 32'h0000_2000, 32'hAABB_CCDD, 32'h0,         3};
        vecs[2] = '{1'b1, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'h0,         32'h0000_005A, 3};
        vecs[3] = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,         32'h0201_5AA5, 6};
        vecs[4] = '{1'b1, 1'b0, 2'd1, 32'h0000_2000, 32'h0,         32'h0000_CCDD, 4};
        vecs[5] = '{1'b1, 1'b1, 2'd3, 32'h0000_0300, 32'h1234_5678, 32'h0,         5};
        vecs[6] = '{1'b1, 1'b0, 2'd3, 32'h0000_0300, 32'h0,         32'h1234_5678, 6};

        // reset with both requesters already pending
        if_req = 1'b1; if_addr = 32'h0000_0100;
        mm_req = 1'b1; mm_wr = 1'b0; mm_len = 2'd0; mm_addr = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_a",    mem_a, 32'h0);
        check("rst_mem_wr",   {31'h0, mem_wr}, 32'h0);
        check("rst_mem_dout", {24'h0, mem_dout}, 32'h0);
        check("rst_dones",    {30'h0, if_done, mm_done}, 32'h0);
        check("rst_rdata",    if_rdata | mm_rdata, 32'h0);
        check("rst_busy",     {31'h0, busy}, 32'h0);
        check("rst_state",    {29'h0, fsm_state}, 32'h0);

        // arbitration: MM first after reset, then alternate while both held
        exp_q.push_back({2'd1, 6'd3});
        exp_q.push_back({2'd2, 6'd10});
        exp_q.push_back({2'd1, 6'd14});
        @(posedge clk); #1;
        rst = 1'b1; ram_load = 1'b0;
        done_cnt = 0;
        for (int off = 0; off < 40 && done_cnt < 3; off++) begin
            @(negedge clk);
            if (mm_done || if_done) begin
                act_ev = {(mm_done ? 2'd1 : 2'd2), 6'(off)};
                check($sformatf("alt_done%0d", done_cnt), {24'h0, act_ev}, {24'h0, exp_q.pop_front()});
                if (done_cnt == 1) check("alt_if_rdata", if_rdata, 32'h4433_2211);
                else               check("alt_mm_rdata", mm_rdata, 32'h0000_005A);
                done_cnt++;
            end
            @(posedge clk); #1;
        end
        if_req = 1'b0; mm_req = 1'b0;
        check("alt_all_seen", done_cnt, 3);
        exp_q.delete();
        next_cycle();

        // table of single transactions
        for (int v = 0; v < NV; v++) begin
            t = vecs[v];
            n = !t.is_mm ? 4 : (t.len == 2'd0 ? 1 : (t.len == 2'd1 ? 2 : 4));
            run_txn(t.is_mm, t.wr, t.len, t.addr, t.wdata, -1, lat, rdata);
            check($sformatf("v%0d_latency", v), lat, t.exp_lat);
            if (!t.wr) check($sformatf("v%0d_rdata", v), rdata, t.exp_rdata);
            check($sformatf("v%0d_busy_T", v), {31'h0, tr_busy[0]}, 32'h0);
            check($sformatf("v%0d_busy_T1", v), {31'h0, tr_busy[1]}, 32'h1);
            for (int k = 0; k < n; k++) begin
                ea = t.addr + k;
                check($sformatf("v%0d_mem_a%0d", v, k), tr_a[k+1], ea);
                if (t.wr) begin
                    check($sformatf("v%0d_mem_wr%0d", v, k), {31'h0, tr_wr[k+1]}, 32'h1);
                    check($sformatf("v%0d_dout%0d", v, k), {24'h0, tr_dout[k+1]}, {24'h0, t.wdata[8*k +: 8]});
                    check($sformatf("v%0d_ram%0d", v, k), {24'h0, ram[ea[13:0]]}, {24'h0, t.wdata[8*k +: 8]});
                end
            end
            if (t.wr) check($sformatf("v%0d_wr_off_fin", v), {31'h0, tr_wr[n+1]}, 32'h0);
            @(negedge clk);
            check($sformatf("v%0d_idle_after", v), {29'h0, if_done, mm_done, busy}, 32'h0);
            next_cycle();
        end
        check("v1_ram_2002_untouched", {24'h0, ram[14'h2002]}, 32'h0000_00EE);

        // flush during RD byte 2 of an IF read aborts it
        if_req = 1'b1; if_addr = 32'h0000_0100;
        next_cycle(); next_cycle(); next_cycle();
        if_flush = 1'b1;
        @(negedge clk);
        check("flush_mem_a_byte2", mem_a, 32'h0000_0102);
        next_cycle();
        if_flush = 1'b0; if_req = 1'b0;
        @(negedge clk);
        check("flush_to_idle", {31'h0, busy}, 32'h0);
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            if (if_done) pulses++;
            @(negedge clk);
        end
        check("flush_no_done", pulses, 0);
        check("flush_rdata_kept", if_rdata, 32'h4433_2211);
        next_cycle();
        run_txn(1'b0, 1'b0, 2'd0, 32'h0000_0200, 32'h0, -1, lat, rdata);
        check("after_flush_latency", lat, 6);
        check("after_flush_rdata", rdata, 32'h697A_8B9C);
        next_cycle();

        // flush on the done cycle is ignored
        run_txn(1'b0, 1'b0, 2'd0, 32'h0000_0100, 32'h0, 6, lat, rdata);
        check("fin_flush_latency", lat, 6);
        check("fin_flush_rdata", rdata, 32'h4433_2211);
        next_cycle();

        // MM read is not affected by if_flush
        run_txn(1'b1, 1'b0, 2'd2, 32'h0000_0200, 32'h0, 3, lat, rdata);
        check("mm_flush_latency", lat, 6);
        check("mm_flush_rdata", rdata, 32'h697A_8B9C);
        next_cycle();

        // reset in the middle of a 4-byte write, then retry
        mm_req = 1'b1; mm_wr = 1'b1; mm_len = 2'd2;
        mm_addr = 32'h0000_0400; mm_wdata = 32'hCAFE_F00D;
        next_cycle(); next_cycle(); next_cycle();
        rst = 1'b0; mm_req = 1'b0;
        #1;
        check("rstmid_mem_wr", {31'h0, mem_wr}, 32'h0);
        check("rstmid_no_done", {31'h0, mm_done}, 32'h0);
        check("rstmid_busy", {31'h0, busy}, 32'h0);
        check("rstmid_mem_a", mem_a, 32'h0);
        next_cycle(); next_cycle();
        check("rstmid_ram400", {24'h0, ram[14'h0400]}, 32'h0000_000D);
        check("rstmid_ram401", {24'h0, ram[14'h0401]}, 32'h0000_00F0);
        check("rstmid_ram402", {24'h0, ram[14'h0402]}, 32'h0000_00EE);
        rst = 1'b1;
        next_cycle();
        run_txn(1'b1, 1'b1, 2'd2, 32'h0000_0400, 32'hCAFE_F00D, -1, lat, rdata);
        check("retry_latency", lat, 5);
        check("retry_ram", {ram[14'h0403], ram[14'h0402], ram[14'h0401], ram[14'h0400]}, 32'hCAFE_F00D);

        // report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
